// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter: FSM state
// encodings and requester/select widths.
package mux8_rr_arbiter_pkg;

    localparam int NREQ  = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

endpackage : mux8_rr_arbiter_pkg

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the requesting units (master) and the
// arbiter (slave) that drives the shared mux select.
interface mux8_rr_arbiter_if
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_W = 8
) ();

    logic [NREQ-1:0]   req;
    logic              arb_en;
    logic [SEL_W-1:0]  select;
    logic [NREQ-1:0]   grant;
    logic              sel_valid;
    logic [HOLD_W-1:0] hold_cnt;

    modport master (
        output req, arb_en,
        input  select, grant, sel_valid, hold_cnt
    );

    modport slave (
        input  req, arb_en,
        output select, grant, sel_valid, hold_cnt
    );

endinterface : mux8_rr_arbiter_if

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Combinational round-robin picker: first set request bit scanning from
// ptr_i upward with wrap 7->0.
module rr_pick8
    import mux8_rr_arbiter_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             found_o
);

    logic [NREQ-1:0]  rot;
    logic [SEL_W-1:0] off;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        rot = '0;
        off = '0;
        for (int j = 0; j < NREQ; j++) begin
            rot[j] = req_i[ptr_i + SEL_W'(j)];
        end
        // Descending scan so the lowest set bit of the rotated vector wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) off = SEL_W'(i);
        end
        idx_o   = ptr_i + off;
        found_o = |req_i;
    end

endmodule : rr_pick8

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 mux among 8 level requesters, with a
// hold limit and a one-cycle break-before-make gap between owners.
module mux8_rr_arbiter
    import mux8_rr_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux8_rr_arbiter_if.slave bus
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT =
        (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [SEL_W-1:0]  select_q, select_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              sel_valid_q, sel_valid_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [SEL_W-1:0]  win_idx;
    logic              win_found;
    logic              limit_hit;
    logic              release_grant;

    rr_pick8 u_pick (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .idx_o   (win_idx),
        .found_o (win_found)
    );

    // The limit only bites when someone else is actually waiting.
    assign limit_hit = (MAX_HOLD != 0) && (hold_cnt_q >= HOLD_LIMIT)
                       && (|(bus.req & ~grant_q));
    assign release_grant = !bus.req[select_q] || limit_hit;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        select_d    = select_q;
        grant_d     = grant_q;
        sel_valid_d = sel_valid_q;
        hold_cnt_d  = hold_cnt_q;

        unique case (state_q)
            ST_GRANT: begin
                hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_cnt_q + 1'b1;
                if (release_grant) begin
                    state_d     = ST_GAP;
                    ptr_d       = select_q + 1'b1;
                    grant_d     = '0;
                    sel_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; select is left untouched when idle.
                if (bus.arb_en && win_found) begin
                    state_d     = ST_GRANT;
                    select_d    = win_idx;
                    grant_d     = NREQ'(1) << win_idx;
                    sel_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                end else begin
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    sel_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            select_q    <= '0;
            grant_q     <= '0;
            sel_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            select_q    <= select_d;
            grant_q     <= grant_d;
            sel_valid_q <= sel_valid_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign bus.select    = select_q;
    assign bus.grant     = grant_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.hold_cnt  = hold_cnt_q;

endmodule : mux8_rr_arbiter

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter (MAX_HOLD=4): directed stimulus queues
// expected grants, a negedge monitor pops and checks each new grant.
module tb_mux8_rr_arbiter;
    import mux8_rr_arbiter_pkg::*;

    typedef struct {
        logic [7:0] grant;
        logic [2:0] select;
        int         hold_len;   // cycles grant stays up; 0 = unchecked
        int         start_gap;  // cycles since previous grant start; 0 = unchecked
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   test_cnt = 0;
    int   fail_cnt = 0;
    bit   mon_en = 1'b0;
    exp_t exp_q[$];

    mux8_rr_arbiter_if #(.HOLD_W(8)) bus ();

    mux8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        test_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] g, input logic [2:0] s, input int len, input int gap);
        exp_t e;
        e.grant = g; e.select = s; e.hold_len = len; e.start_gap = gap;
        exp_q.push_back(e);
    endtask

    // Monitor: invariants every cycle, grant events against the scoreboard.
    initial begin
        exp_t       cur_exp;
        bit         cur_active = 1'b0;
        logic [7:0] cur_grant  = '0;
        int         cur_len    = 0;
        int         cyc        = 0;
        int         last_start = 0;
        bit         inv_ok;
        cur_exp.hold_len = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                inv_ok = $onehot0(bus.grant) && (bus.sel_valid == (|bus.grant))
                         && ((bus.grant == 8'h00) || bus.grant[bus.select]);
                check("invariants", 32'(inv_ok), 32'd1);
                if (cur_active && bus.grant != cur_grant) begin
                    if (cur_exp.hold_len != 0) check("hold_len", cur_len, cur_exp.hold_len);
                    cur_active = 1'b0;
                end
                if (cur_active) cur_len++;
                if (bus.sel_valid && !cur_active) begin
                    if (exp_q.size() == 0) begin
                        test_cnt++;
                        fail_cnt++;
                        $display("FAIL unexpected_grant: got %0h expected none", bus.grant);
                        cur_exp.hold_len = 0;
                    end else begin
                        cur_exp = exp_q.pop_front();
                        check("grant", bus.grant, cur_exp.grant);
                        check("select", bus.select, cur_exp.select);
                        check("hold_cnt_start", bus.hold_cnt, 32'd0);
                        if (cur_exp.start_gap != 0)
                            check("grant_period", cyc - last_start, cur_exp.start_gap);
                    end
                    cur_active = 1'b1;
                    cur_grant  = bus.grant;
                    cur_len    = 1;
                    last_start = cyc;
                end
            end
        end
    end

    initial begin
        bus.req    = 8'h00;
        bus.arb_en = 1'b1;

        // 1: reset state
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        check("rst_grant", bus.grant, 8'h00);
        check("rst_sel_valid", bus.sel_valid, 1'b0);
        check("rst_select", bus.select, 3'd0);
        check("rst_hold_cnt", bus.hold_cnt, 8'd0);
        mon_en = 1'b1;

        // 2: single requester, one-cycle latency, release into gap
        push(8'h10, 3'd4, 4, 0);
        bus.req = 8'h10;
        step(1);
        check("t2_grant_latency", bus.grant, 8'h10);
        step(3);
        bus.req = 8'h00;
        step(1);
        check("t2_gap_grant", bus.grant, 8'h00);
        check("t2_gap_select", bus.select, 3'd4);
        step(1);
        check("t2_idle_valid", bus.sel_valid, 1'b0);
        check("t2_idle_select", bus.select, 3'd4);

        // 3: all requesting, hold limit rotates 0..7,0 with period 5
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(1 << i), 3'(i), 4, (i == 0) ? 0 : 5);
        push(8'h01, 3'd0, 0, 5);
        bus.req = 8'hFF;
        step(41);
        bus.req = 8'h00;
        step(2);

        // 4: owner 6 released by limit, ptr=7 wraps to requester 0
        push(8'h40, 3'd6, 4, 0);
        push(8'h01, 3'd0, 0, 5);
        bus.req = 8'h40;
        step(1);
        bus.req = 8'h41;
        step(5);
        check("t4_wrap_winner", bus.grant, 8'h01);
        bus.req = 8'h00;
        step(2);

        // 5: lone owner is never released; hold_cnt keeps counting
        push(8'h04, 3'd2, 20, 0);
        bus.req = 8'h04;
        step(20);
        check("t5_lone_grant", bus.grant, 8'h04);
        check("t5_hold_cnt", bus.hold_cnt, 8'd19);
        bus.req = 8'h00;
        step(2);

        // 6: reset mid-grant of owner 5, ptr back to 0
        push(8'h20, 3'd5, 3, 0);
        bus.req = 8'h20;
        step(3);
        rst = 1'b1;
        bus.req = 8'h21;
        step(1);
        check("t6_rst_grant", bus.grant, 8'h00);
        check("t6_rst_select", bus.select, 3'd0);
        rst = 1'b0;
        push(8'h01, 3'd0, 0, 0);
        step(1);
        check("t6_post_rst_winner", bus.grant, 8'h01);
        bus.req = 8'h00;
        step(2);

        // arb_en low blocks new grants
        bus.arb_en = 1'b0;
        bus.req    = 8'hFF;
        step(2);
        check("arb_en_off_valid", bus.sel_valid, 1'b0);
        bus.req    = 8'h00;
        bus.arb_en = 1'b1;
        step(2);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule : tb_mux8_rr_arbiter
